// File: rtl/proc_sequencer.sv
// Instruction sequencer for the 10-bit processor: latches INSTR on Exec and walks timesteps T0..T3.
// Latency: LOAD/MOV return to T0 two cycles after Exec, ALU ops four; enables are combinational.
// Backpressure: Exec is ignored while busy; with PROC_SEQ_STEP_EN defined, T1..T3 advance only on Step.
module proc_sequencer #(
  parameter int         AW     = 2,
  parameter logic [9:0] IR_RST = 10'b0
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [9:0]    INSTR,
  input  logic          Exec,
`ifdef PROC_SEQ_STEP_EN
  input  logic          Step,
`endif
  output logic          IRin,
  output logic          Ext,
  output logic          ENR,
  output logic [AW-1:0] RDA0,
  output logic          ENW,
  output logic [AW-1:0] WRA,
  output logic          Ain,
  output logic          Gin,
  output logic          Gout,
  output logic [2:0]    FN,
  output logic [1:0]    TIME,
  output logic          Clr,
  output logic          BUSY
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_t;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b111;

  tstep_t       state, state_nxt;
  logic [9:0]   ir;
  logic [2:0]   op;
  logic [AW-1:0] rx, ry;
  logic         adv;
  logic         unused_ir;

  assign op        = ir[9:7];
  assign rx        = ir[6:5];
  assign ry        = ir[4:3];
  assign unused_ir = ^ir[2:0];

`ifdef PROC_SEQ_STEP_EN
  assign adv = Step;
`else
  assign adv = 1'b1;
`endif

  // Timestep register and instruction capture; IR only loads when idle and Exec arrives
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= T0;
      ir    <= IR_RST;
    end else begin
      state <= state_nxt;
      if (state == T0 && Exec)
        ir <= INSTR;
    end
  end

  // Next timestep and per-step datapath enables; everything forced low while Reset is high
  always_comb begin
    state_nxt = state;
    IRin = 1'b0;
    Ext  = 1'b0;
    ENR  = 1'b0;
    RDA0 = '0;
    ENW  = 1'b0;
    WRA  = '0;
    Ain  = 1'b0;
    Gin  = 1'b0;
    Gout = 1'b0;
    FN   = 3'b000;
    Clr  = 1'b0;
    case (state)
      T0: begin
        if (Exec) begin
          IRin      = 1'b1;
          state_nxt = T1;
        end
      end
      T1: begin
        if (op == OP_LOAD) begin
          Ext = 1'b1;
          ENW = 1'b1;
          WRA = rx;
          Clr = 1'b1;
          if (adv) state_nxt = T0;
        end else if (op == OP_MOV) begin
          ENR  = 1'b1;
          RDA0 = ry;
          ENW  = 1'b1;
          WRA  = rx;
          Clr  = 1'b1;
          if (adv) state_nxt = T0;
        end else begin
          ENR  = 1'b1;
          RDA0 = rx;
          Ain  = 1'b1;
          if (adv) state_nxt = T2;
        end
      end
      T2: begin
        // LOAD/MOV never reach T2; recover to idle without touching the datapath
        if (op == OP_LOAD || op == OP_MOV) begin
          state_nxt = T0;
        end else begin
          Gin = 1'b1;
          FN  = op;
          if (op != OP_NOT) begin
            ENR  = 1'b1;
            RDA0 = ry;
          end
          if (adv) state_nxt = T3;
        end
      end
      default: begin
        if (op == OP_LOAD || op == OP_MOV) begin
          state_nxt = T0;
        end else begin
          Gout = 1'b1;
          ENW  = 1'b1;
          WRA  = rx;
          Clr  = 1'b1;
          if (adv) state_nxt = T0;
        end
      end
    endcase
    // Reset kills enables in the same cycle so no partial write lands
    if (Reset) begin
      IRin = 1'b0;
      Ext  = 1'b0;
      ENR  = 1'b0;
      RDA0 = '0;
      ENW  = 1'b0;
      WRA  = '0;
      Ain  = 1'b0;
      Gin  = 1'b0;
      Gout = 1'b0;
      FN   = 3'b000;
      Clr  = 1'b0;
    end
  end

  assign TIME = state;
  assign BUSY = (state != T0);

endmodule
